// File: rtl/snitch_narrow_id_remap.sv
// snitch_narrow_id_remap
//   Compacts the AXI IDs of the Snitch cluster narrow outbound master port
//   (InIdWidth bits) into a small OutIdWidth ID space ahead of the SoC
//   crossbar. Independent write (AW/B) and read (AR/R) remap tables track
//   outstanding transactions per slot and restore the original ID on
//   responses, so AXI per-ID ordering is preserved. The data path is purely
//   combinational; only the remap tables are registered.
//
//   Ports (top):
//     clk_i       in   clock
//     rst_i       in   asynchronous active-high reset (clears both tables)
//     slv_req_i   in   AXI request from the cluster narrow-out port
//     slv_resp_o  out  AXI response to the cluster
//     mst_req_o   out  AXI request to the SoC interconnect (compacted IDs)
//     mst_resp_i  in   AXI response from the SoC interconnect

package snitch_cluster_cfg_pkg;

   localparam int unsigned NarrowIdWidthOut = 4;
   localparam int unsigned SocNarrowIdWidth = 2;
   localparam int unsigned NarrowAddrWidth  = 32;
   localparam int unsigned NarrowDataWidth  = 64;
   localparam int unsigned NarrowUserWidth  = 1;

   typedef logic [NarrowIdWidthOut-1:0]  narrow_out_id_t;
   typedef logic [SocNarrowIdWidth-1:0]  soc_narrow_id_t;
   typedef logic [NarrowAddrWidth-1:0]   narrow_addr_t;
   typedef logic [NarrowDataWidth-1:0]   narrow_data_t;
   typedef logic [NarrowDataWidth/8-1:0] narrow_strb_t;
   typedef logic [NarrowUserWidth-1:0]   narrow_user_t;

   typedef struct packed {
      narrow_out_id_t id;
      narrow_addr_t   addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
      logic           lock;
      logic [3:0]     cache;
      logic [2:0]     prot;
      logic [3:0]     qos;
      logic [3:0]     region;
      logic [5:0]     atop;
      narrow_user_t   user;
   } narrow_out_aw_chan_t;

   typedef struct packed {
      soc_narrow_id_t id;
      narrow_addr_t   addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
      logic           lock;
      logic [3:0]     cache;
      logic [2:0]     prot;
      logic [3:0]     qos;
      logic [3:0]     region;
      logic [5:0]     atop;
      narrow_user_t   user;
   } soc_narrow_aw_chan_t;

   typedef struct packed {
      narrow_out_id_t id;
      narrow_addr_t   addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
      logic           lock;
      logic [3:0]     cache;
      logic [2:0]     prot;
      logic [3:0]     qos;
      logic [3:0]     region;
      narrow_user_t   user;
   } narrow_out_ar_chan_t;

   typedef struct packed {
      soc_narrow_id_t id;
      narrow_addr_t   addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
      logic           lock;
      logic [3:0]     cache;
      logic [2:0]     prot;
      logic [3:0]     qos;
      logic [3:0]     region;
      narrow_user_t   user;
   } soc_narrow_ar_chan_t;

   typedef struct packed {
      narrow_data_t data;
      narrow_strb_t strb;
      logic         last;
      narrow_user_t user;
   } narrow_w_chan_t;

   typedef struct packed {
      narrow_out_id_t id;
      logic [1:0]     resp;
      narrow_user_t   user;
   } narrow_out_b_chan_t;

   typedef struct packed {
      soc_narrow_id_t id;
      logic [1:0]     resp;
      narrow_user_t   user;
   } soc_narrow_b_chan_t;

   typedef struct packed {
      narrow_out_id_t id;
      narrow_data_t   data;
      logic [1:0]     resp;
      logic           last;
      narrow_user_t   user;
   } narrow_out_r_chan_t;

   typedef struct packed {
      soc_narrow_id_t id;
      narrow_data_t   data;
      logic [1:0]     resp;
      logic           last;
      narrow_user_t   user;
   } soc_narrow_r_chan_t;

   typedef struct packed {
      narrow_out_aw_chan_t aw;
      logic                aw_valid;
      narrow_w_chan_t      w;
      logic                w_valid;
      logic                b_ready;
      narrow_out_ar_chan_t ar;
      logic                ar_valid;
      logic                r_ready;
   } narrow_out_req_t;

   typedef struct packed {
      logic               aw_ready;
      logic               ar_ready;
      logic               w_ready;
      logic               b_valid;
      narrow_out_b_chan_t b;
      logic               r_valid;
      narrow_out_r_chan_t r;
   } narrow_out_resp_t;

   typedef struct packed {
      soc_narrow_aw_chan_t aw;
      logic                aw_valid;
      narrow_w_chan_t      w;
      logic                w_valid;
      logic                b_ready;
      soc_narrow_ar_chan_t ar;
      logic                ar_valid;
      logic                r_ready;
   } soc_narrow_req_t;

   typedef struct packed {
      logic               aw_ready;
      logic               ar_ready;
      logic               w_ready;
      logic               b_valid;
      soc_narrow_b_chan_t b;
      logic               r_valid;
      soc_narrow_r_chan_t r;
   } soc_narrow_resp_t;

endpackage

// snitch_narrow_id_remap_table
//   One direction's remap table: NumSlots entries {valid, in_id, cnt}.
//   Ports:
//     i_clk, i_rst     clock, async active-high reset
//     i_req_id         incoming request ID to look up
//     i_req_hs         request handshake this cycle (allocate/increment)
//     i_rsp_id         compacted ID of the response beat
//     i_rsp_dec        response completes a transaction (decrement)
//     o_can_issue      request may be forwarded (state + ID only)
//     o_out_id         compacted ID for the request
//     o_rsp_in_id      original ID restored for the response
module snitch_narrow_id_remap_table #(
   parameter int unsigned InIdWidth    = 4,
   parameter int unsigned OutIdWidth   = 2,
   parameter int unsigned MaxTxnsPerId = 8
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [InIdWidth-1:0]  i_req_id,
   input  logic                  i_req_hs,
   input  logic [OutIdWidth-1:0] i_rsp_id,
   input  logic                  i_rsp_dec,
   output logic                  o_can_issue,
   output logic [OutIdWidth-1:0] o_out_id,
   output logic [InIdWidth-1:0]  o_rsp_in_id
);

   localparam int unsigned NumSlots = 2 ** OutIdWidth;
   localparam int unsigned CntW     = $clog2(MaxTxnsPerId + 1);

   logic [NumSlots-1:0]  r_valid;
   logic [InIdWidth-1:0] r_in_id [NumSlots];
   logic [CntW-1:0]      r_cnt   [NumSlots];

   logic                  w_hit;
   logic [OutIdWidth-1:0] w_hit_idx;
   logic                  w_free;
   logic [OutIdWidth-1:0] w_free_idx;
   logic [NumSlots-1:0]   w_inc;
   logic [NumSlots-1:0]   w_dec;

   // At most one valid slot can match, since allocation only happens on a miss.
   always_comb begin
      w_hit      = 1'b0;
      w_hit_idx  = '0;
      w_free     = 1'b0;
      w_free_idx = '0;
      for (int unsigned i = 0; i < NumSlots; i++) begin
         if (r_valid[i] && (r_in_id[i] == i_req_id)) begin
            w_hit     = 1'b1;
            w_hit_idx = OutIdWidth'(i);
         end
         if (!r_valid[i] && !w_free) begin
            w_free     = 1'b1;
            w_free_idx = OutIdWidth'(i);
         end
      end
   end

   assign o_can_issue = w_hit ? (r_cnt[w_hit_idx] < CntW'(MaxTxnsPerId)) : w_free;
   assign o_out_id    = w_hit ? w_hit_idx : w_free_idx;
   assign o_rsp_in_id = r_in_id[i_rsp_id];

   always_comb begin
      w_inc = '0;
      w_dec = '0;
      for (int unsigned i = 0; i < NumSlots; i++) begin
         w_inc[i] = i_req_hs  && (o_out_id == OutIdWidth'(i));
         w_dec[i] = i_rsp_dec && (i_rsp_id == OutIdWidth'(i));
      end
   end

   // Simultaneous increment and decrement leaves the entry untouched, which
   // keeps a cnt==1 slot alive when its in_id is reissued in the same cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < NumSlots; i++) begin
            r_valid[i] <= 1'b0;
            r_in_id[i] <= '0;
            r_cnt[i]   <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NumSlots; i++) begin
            if (w_inc[i] && !w_dec[i]) begin
               r_valid[i] <= 1'b1;
               r_in_id[i] <= i_req_id;
               r_cnt[i]   <= r_cnt[i] + CntW'(1);
            end else if (w_dec[i] && !w_inc[i] && r_valid[i]) begin
               r_cnt[i] <= r_cnt[i] - CntW'(1);
               if (r_cnt[i] == CntW'(1)) begin
                  r_valid[i] <= 1'b0;
               end
            end
         end
      end
   end

   a_rsp_on_valid_slot: assert property (@(posedge i_clk) disable iff (i_rst)
      i_rsp_dec |-> r_valid[i_rsp_id]);

   for (genvar g = 0; g < NumSlots; g++) begin : g_cnt_chk
      a_cnt_range: assert property (@(posedge i_clk) disable iff (i_rst)
         r_cnt[g] <= CntW'(MaxTxnsPerId));
   end

endmodule

module snitch_narrow_id_remap #(
   parameter int unsigned InIdWidth    = snitch_cluster_cfg_pkg::NarrowIdWidthOut,
   parameter int unsigned OutIdWidth   = 2,
   parameter int unsigned MaxTxnsPerId = 8,
   parameter type slv_req_t  = snitch_cluster_cfg_pkg::narrow_out_req_t,
   parameter type slv_resp_t = snitch_cluster_cfg_pkg::narrow_out_resp_t,
   parameter type mst_req_t  = snitch_cluster_cfg_pkg::soc_narrow_req_t,
   parameter type mst_resp_t = snitch_cluster_cfg_pkg::soc_narrow_resp_t
) (
   input  logic      clk_i,
   input  logic      rst_i,
   input  slv_req_t  slv_req_i,
   output slv_resp_t slv_resp_o,
   output mst_req_t  mst_req_o,
   input  mst_resp_t mst_resp_i
);

   logic                  w_aw_can, w_ar_can;
   logic [OutIdWidth-1:0] w_aw_out_id, w_ar_out_id;
   logic [InIdWidth-1:0]  w_b_in_id, w_r_in_id;
   logic                  w_aw_hs, w_ar_hs, w_b_dec, w_r_dec;

   assign w_aw_hs = slv_req_i.aw_valid & mst_resp_i.aw_ready & w_aw_can;
   assign w_ar_hs = slv_req_i.ar_valid & mst_resp_i.ar_ready & w_ar_can;
   assign w_b_dec = mst_resp_i.b_valid & slv_req_i.b_ready;
   // A read transaction completes only on its last beat.
   assign w_r_dec = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;

   snitch_narrow_id_remap_table #(
      .InIdWidth   (InIdWidth),
      .OutIdWidth  (OutIdWidth),
      .MaxTxnsPerId(MaxTxnsPerId)
   ) u_wtab (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_req_id   (slv_req_i.aw.id),
      .i_req_hs   (w_aw_hs),
      .i_rsp_id   (mst_resp_i.b.id),
      .i_rsp_dec  (w_b_dec),
      .o_can_issue(w_aw_can),
      .o_out_id   (w_aw_out_id),
      .o_rsp_in_id(w_b_in_id)
   );

   snitch_narrow_id_remap_table #(
      .InIdWidth   (InIdWidth),
      .OutIdWidth  (OutIdWidth),
      .MaxTxnsPerId(MaxTxnsPerId)
   ) u_rtab (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_req_id   (slv_req_i.ar.id),
      .i_req_hs   (w_ar_hs),
      .i_rsp_id   (mst_resp_i.r.id),
      .i_rsp_dec  (w_r_dec),
      .o_can_issue(w_ar_can),
      .o_out_id   (w_ar_out_id),
      .o_rsp_in_id(w_r_in_id)
   );

   always_comb begin
      mst_req_o           = '0;
      mst_req_o.aw.id     = w_aw_out_id;
      mst_req_o.aw.addr   = slv_req_i.aw.addr;
      mst_req_o.aw.len    = slv_req_i.aw.len;
      mst_req_o.aw.size   = slv_req_i.aw.size;
      mst_req_o.aw.burst  = slv_req_i.aw.burst;
      mst_req_o.aw.lock   = slv_req_i.aw.lock;
      mst_req_o.aw.cache  = slv_req_i.aw.cache;
      mst_req_o.aw.prot   = slv_req_i.aw.prot;
      mst_req_o.aw.qos    = slv_req_i.aw.qos;
      mst_req_o.aw.region = slv_req_i.aw.region;
      mst_req_o.aw.atop   = slv_req_i.aw.atop;
      mst_req_o.aw.user   = slv_req_i.aw.user;
      mst_req_o.aw_valid  = slv_req_i.aw_valid & w_aw_can;
      mst_req_o.w         = slv_req_i.w;
      mst_req_o.w_valid   = slv_req_i.w_valid;
      mst_req_o.b_ready   = slv_req_i.b_ready;
      mst_req_o.ar.id     = w_ar_out_id;
      mst_req_o.ar.addr   = slv_req_i.ar.addr;
      mst_req_o.ar.len    = slv_req_i.ar.len;
      mst_req_o.ar.size   = slv_req_i.ar.size;
      mst_req_o.ar.burst  = slv_req_i.ar.burst;
      mst_req_o.ar.lock   = slv_req_i.ar.lock;
      mst_req_o.ar.cache  = slv_req_i.ar.cache;
      mst_req_o.ar.prot   = slv_req_i.ar.prot;
      mst_req_o.ar.qos    = slv_req_i.ar.qos;
      mst_req_o.ar.region = slv_req_i.ar.region;
      mst_req_o.ar.user   = slv_req_i.ar.user;
      mst_req_o.ar_valid  = slv_req_i.ar_valid & w_ar_can;
      mst_req_o.r_ready   = slv_req_i.r_ready;
   end

   always_comb begin
      slv_resp_o          = '0;
      slv_resp_o.aw_ready = mst_resp_i.aw_ready & w_aw_can;
      slv_resp_o.ar_ready = mst_resp_i.ar_ready & w_ar_can;
      slv_resp_o.w_ready  = mst_resp_i.w_ready;
      slv_resp_o.b_valid  = mst_resp_i.b_valid;
      slv_resp_o.b.id     = w_b_in_id;
      slv_resp_o.b.resp   = mst_resp_i.b.resp;
      slv_resp_o.b.user   = mst_resp_i.b.user;
      slv_resp_o.r_valid  = mst_resp_i.r_valid;
      slv_resp_o.r.id     = w_r_in_id;
      slv_resp_o.r.data   = mst_resp_i.r.data;
      slv_resp_o.r.resp   = mst_resp_i.r.resp;
      slv_resp_o.r.last   = mst_resp_i.r.last;
      slv_resp_o.r.user   = mst_resp_i.r.user;
   end

endmodule

// File: tb/tb_snitch_narrow_id_remap.sv
// tb_snitch_narrow_id_remap
//   Directed test of snitch_narrow_id_remap: inputs change 1 time unit after
//   the rising edge, outputs are compared a further 1 time unit later.
module tb_snitch_narrow_id_remap;
   import snitch_cluster_cfg_pkg::*;

   logic             clk;
   logic             rst;
   narrow_out_req_t  slv_req;
   narrow_out_resp_t slv_resp;
   soc_narrow_req_t  mst_req;
   soc_narrow_resp_t mst_resp;

   int unsigned tests = 0;
   int unsigned fails = 0;

   snitch_narrow_id_remap #(
      .InIdWidth   (NarrowIdWidthOut),
      .OutIdWidth  (2),
      .MaxTxnsPerId(8),
      .slv_req_t   (narrow_out_req_t),
      .slv_resp_t  (narrow_out_resp_t),
      .mst_req_t   (soc_narrow_req_t),
      .mst_resp_t  (soc_narrow_resp_t)
   ) dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .slv_req_i (slv_req),
      .slv_resp_o(slv_resp),
      .mst_req_o (mst_req),
      .mst_resp_i(mst_resp)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [3:0] ids4 [4];
      logic [1:0] bslot [4];
      logic [3:0] bexp  [4];

      rst      = 1'b1;
      slv_req  = '0;
      mst_resp = '0;
      slv_req.b_ready = 1'b1;
      slv_req.r_ready = 1'b1;

      // Reset: empty tables, first miss allocates slot 0.
      #3;
      slv_req.aw_valid = 1'b1;
      slv_req.aw.id    = 4'h5;
      #1;
      chk("rst_aw_id", 64'(mst_req.aw.id), 64'h0);
      chk("rst_aw_valid", 64'(mst_req.aw_valid), 64'h1);
      slv_req.aw_valid = 1'b0;
      #8;
      rst = 1'b0;
      mst_resp.aw_ready = 1'b1;
      mst_resp.ar_ready = 1'b1;
      mst_resp.w_ready  = 1'b1;

      // T1: single write ID 0x5.
      tick();
      slv_req.aw_valid = 1'b1;
      slv_req.aw.id    = 4'h5;
      slv_req.aw.addr  = 32'h0000_1234;
      #1;
      chk("t1_aw_valid", 64'(mst_req.aw_valid), 64'h1);
      chk("t1_aw_id", 64'(mst_req.aw.id), 64'h0);
      chk("t1_aw_ready", 64'(slv_resp.aw_ready), 64'h1);
      chk("t1_aw_addr", 64'(mst_req.aw.addr), 64'h1234);
      tick();
      slv_req.aw.id     = 4'h6;
      mst_resp.aw_ready = 1'b0;
      mst_resp.b_valid  = 1'b1;
      mst_resp.b.id     = 2'd0;
      #1;
      chk("t1_b_id", 64'(slv_resp.b.id), 64'h5);
      chk("t1_b_valid", 64'(slv_resp.b_valid), 64'h1);
      chk("t1_busy_slot_alloc", 64'(mst_req.aw.id), 64'h1);
      chk("t1_aw_ready_gated", 64'(slv_resp.aw_ready), 64'h0);
      tick();
      mst_resp.b_valid = 1'b0;
      #1;
      chk("t1_freed_alloc", 64'(mst_req.aw.id), 64'h0);
      slv_req.aw_valid  = 1'b0;
      mst_resp.aw_ready = 1'b1;

      // T2: four IDs fill the table, 0x7 stalls until B on slot 2.
      ids4  = '{4'h1, 4'h2, 4'h3, 4'h4};
      for (int i = 0; i < 4; i++) begin
         slv_req.aw_valid = 1'b1;
         slv_req.aw.id    = ids4[i];
         #1;
         chk("t2_fill_id", 64'(mst_req.aw.id), 64'(i));
         tick();
      end
      slv_req.aw.id = 4'h7;
      #1;
      chk("t2_stall_mst_valid", 64'(mst_req.aw_valid), 64'h0);
      chk("t2_stall_slv_ready", 64'(slv_resp.aw_ready), 64'h0);
      tick();
      mst_resp.b_valid = 1'b1;
      mst_resp.b.id    = 2'd2;
      #1;
      chk("t2_b_slot2_id", 64'(slv_resp.b.id), 64'h3);
      chk("t2_stall_during_b", 64'(slv_resp.aw_ready), 64'h0);
      tick();
      mst_resp.b_valid = 1'b0;
      #1;
      chk("t2_unstall_ready", 64'(slv_resp.aw_ready), 64'h1);
      chk("t2_unstall_id", 64'(mst_req.aw.id), 64'h2);
      tick();
      slv_req.aw_valid = 1'b0;
      bslot = '{2'd0, 2'd1, 2'd3, 2'd2};
      bexp  = '{4'h1, 4'h2, 4'h4, 4'h7};
      for (int i = 0; i < 4; i++) begin
         mst_resp.b_valid = 1'b1;
         mst_resp.b.id    = bslot[i];
         #1;
         chk("t2_drain_b_id", 64'(slv_resp.b.id), 64'(bexp[i]));
         tick();
      end
      mst_resp.b_valid = 1'b0;

      // T3: eight ARs on ID 0x3, ninth stalls until an R with last=1.
      for (int i = 0; i < 8; i++) begin
         slv_req.ar_valid = 1'b1;
         slv_req.ar.id    = 4'h3;
         #1;
         chk("t3_ar_id", 64'(mst_req.ar.id), 64'h0);
         tick();
      end
      #1;
      chk("t3_ninth_mst_valid", 64'(mst_req.ar_valid), 64'h0);
      chk("t3_ninth_slv_ready", 64'(slv_resp.ar_ready), 64'h0);
      tick();
      mst_resp.r_valid = 1'b1;
      mst_resp.r.id    = 2'd0;
      mst_resp.r.last  = 1'b0;
      mst_resp.r.data  = 64'hCAFE_F00D_0000_0001;
      #1;
      chk("t3_r_id", 64'(slv_resp.r.id), 64'h3);
      chk("t3_r_data", slv_resp.r.data, 64'hCAFE_F00D_0000_0001);
      tick();
      mst_resp.r_valid = 1'b0;
      #1;
      chk("t3_nonlast_keeps_stall", 64'(slv_resp.ar_ready), 64'h0);
      tick();
      mst_resp.r_valid = 1'b1;
      mst_resp.r.last  = 1'b1;
      #1;
      chk("t3_stall_during_last", 64'(slv_resp.ar_ready), 64'h0);
      tick();
      mst_resp.r_valid = 1'b0;
      #1;
      chk("t3_release_ready", 64'(slv_resp.ar_ready), 64'h1);
      chk("t3_release_id", 64'(mst_req.ar.id), 64'h0);
      tick();
      slv_req.ar_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mst_resp.r_valid = 1'b1;
         mst_resp.r.last  = 1'b1;
         #1;
         chk("t3_drain_r_id", 64'(slv_resp.r.id), 64'h3);
         tick();
      end
      mst_resp.r_valid  = 1'b0;
      slv_req.ar_valid  = 1'b1;
      slv_req.ar.id     = 4'hE;
      mst_resp.ar_ready = 1'b0;
      #1;
      chk("t3_table_empty", 64'(mst_req.ar.id), 64'h0);
      slv_req.ar_valid  = 1'b0;
      mst_resp.ar_ready = 1'b1;

      // T4: same-cycle reissue of ID 0x3 and final B of its slot.
      slv_req.aw_valid = 1'b1;
      slv_req.aw.id    = 4'h3;
      #1;
      chk("t4_first_id", 64'(mst_req.aw.id), 64'h0);
      tick();
      mst_resp.b_valid = 1'b1;
      mst_resp.b.id    = 2'd0;
      #1;
      chk("t4_reissue_id", 64'(mst_req.aw.id), 64'h0);
      chk("t4_reissue_ready", 64'(slv_resp.aw_ready), 64'h1);
      chk("t4_b_id", 64'(slv_resp.b.id), 64'h3);
      tick();
      mst_resp.b_valid  = 1'b0;
      slv_req.aw.id     = 4'h8;
      mst_resp.aw_ready = 1'b0;
      #1;
      chk("t4_slot0_still_valid", 64'(mst_req.aw.id), 64'h1);
      mst_resp.b_valid = 1'b1;
      #1;
      chk("t4_last_b_id", 64'(slv_resp.b.id), 64'h3);
      tick();
      mst_resp.b_valid = 1'b0;
      #1;
      chk("t4_slot0_freed", 64'(mst_req.aw.id), 64'h0);
      slv_req.aw_valid  = 1'b0;
      mst_resp.aw_ready = 1'b1;
      tick();

      // T5: reads and writes on ID 0x6 use independent tables.
      slv_req.aw_valid = 1'b1;
      slv_req.aw.id    = 4'h6;
      slv_req.ar_valid = 1'b1;
      slv_req.ar.id    = 4'h6;
      slv_req.w_valid  = 1'b1;
      slv_req.w.data   = 64'h0000_0000_DEAD_BEEF;
      #1;
      chk("t5_aw_id", 64'(mst_req.aw.id), 64'h0);
      chk("t5_ar_id", 64'(mst_req.ar.id), 64'h0);
      chk("t5_w_data", mst_req.w.data, 64'h0000_0000_DEAD_BEEF);
      chk("t5_w_valid", 64'(mst_req.w_valid), 64'h1);
      tick();
      slv_req.w_valid = 1'b0;
      slv_req.aw.id   = 4'h5;
      #1;
      chk("t5_ar_hit_id", 64'(mst_req.ar.id), 64'h0);
      chk("t5_aw_other_id", 64'(mst_req.aw.id), 64'h1);
      tick();
      slv_req.aw_valid = 1'b0;
      slv_req.ar_valid = 1'b0;
      mst_resp.b_valid = 1'b1;
      mst_resp.b.id    = 2'd0;
      mst_resp.r_valid = 1'b1;
      mst_resp.r.id    = 2'd0;
      mst_resp.r.last  = 1'b1;
      #1;
      chk("t5_b_id", 64'(slv_resp.b.id), 64'h6);
      chk("t5_r_id", 64'(slv_resp.r.id), 64'h6);
      tick();
      mst_resp.b.id = 2'd1;
      #1;
      chk("t5_b_slot1_id", 64'(slv_resp.b.id), 64'h5);
      chk("t5_r_second_id", 64'(slv_resp.r.id), 64'h6);
      tick();
      mst_resp.b_valid = 1'b0;
      mst_resp.r_valid = 1'b0;

      // T6: reset with three outstanding writes.
      ids4 = '{4'hA, 4'hB, 4'hC, 4'h0};
      for (int i = 0; i < 3; i++) begin
         slv_req.aw_valid = 1'b1;
         slv_req.aw.id    = ids4[i];
         #1;
         chk("t6_fill_id", 64'(mst_req.aw.id), 64'(i));
         tick();
      end
      slv_req.aw.id     = 4'hB;
      mst_resp.aw_ready = 1'b0;
      rst = 1'b1;
      #1;
      chk("t6_cleared_in_reset", 64'(mst_req.aw.id), 64'h0);
      rst = 1'b0;
      tick();
      slv_req.aw.id     = 4'h9;
      mst_resp.aw_ready = 1'b1;
      #1;
      chk("t6_post_rst_id", 64'(mst_req.aw.id), 64'h0);
      chk("t6_post_rst_ready", 64'(slv_resp.aw_ready), 64'h1);
      tick();
      slv_req.aw_valid = 1'b0;
      mst_resp.b_valid = 1'b1;
      mst_resp.b.id    = 2'd0;
      #1;
      chk("t6_b_id", 64'(slv_resp.b.id), 64'h9);
      tick();
      mst_resp.b_valid = 1'b0;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
